// File: rtl/branch_ctrl.sv
// ============================================================================
// Module   : branch_ctrl
// Brief    : Run/stall/halt sequencer with compare flag and branch target
//            generation. Optional macro JUMP_LUT_EN selects a 16x8 jump LUT
//            instead of PC-relative targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req,
    input  logic [8:0] Instr,
    input  logic [7:0] PC,
    input  logic       AluZero,
`ifdef JUMP_LUT_EN
    input  logic       LutWe,
    input  logic [3:0] LutAddr,
    input  logic [7:0] LutData,
`endif
    output logic       Start,
    output logic       StallCtr,
    output logic       Jen,
    output logic       Zero,
    output logic [7:0] Jump,
    output logic       Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_CMP = 3'b101;
    localparam logic [2:0] c_OP_MEM = 3'b110;
    localparam logic [2:0] c_OP_BRZ = 3'b111;
    localparam logic [8:0] c_HALT   = 9'h1FF;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       zero_q, zero_d;

    logic       w_start, w_stall, w_jen, w_done;
    logic [7:0] w_target;
    logic [2:0] w_op;
    logic       w_halt;

    assign w_op   = Instr[8:6];
    assign w_halt = (Instr == c_HALT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        w_start = 1'b1;
        w_stall = 1'b0;
        w_jen   = 1'b0;
        w_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    state_d = S_RUN;
                    zero_d  = 1'b0;
                end
            end
            S_RUN: begin
                w_start = 1'b0;
                if (w_halt) begin
                    state_d = S_DONE;
                end else begin
                    case (w_op)
                        // The decoding RUN cycle is stall count 0.
                        c_OP_MEM: begin
                            w_stall = 1'b1;
                            cnt_d   = 2'd1;
                            state_d = S_STALL;
                        end
                        c_OP_CMP: zero_d = AluZero;
                        c_OP_BRZ: w_jen  = 1'b1;
                        default:  ;
                    endcase
                end
            end
            S_STALL: begin
                w_start = 1'b0;
                w_stall = 1'b1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (!Req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef JUMP_LUT_EN
    logic [7:0] lut_q [16];
    logic       w_unused_pc;

    assign w_unused_pc = ^PC;

    // No reset: table contents survive Reset.
    always_ff @(posedge Clk) begin
        if (LutWe && (state_q == S_IDLE)) begin
            lut_q[LutAddr] <= LutData;
        end
    end

    assign w_target = lut_q[Instr[3:0]];
`else
    assign w_target = PC + {{2{Instr[5]}}, Instr[5:0]};
`endif

    // Outputs are forced to their idle values while Reset is held.
    assign Start    = Reset | w_start;
    assign StallCtr = ~Reset & w_stall;
    assign Jen      = ~Reset & w_jen;
    assign Zero     = ~Reset & zero_q;
    assign Done     = ~Reset & w_done;
    assign Jump     = (Jen) ? w_target : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module   : tb_branch_ctrl
// Brief    : Directed self-checking bench for branch_ctrl (JUMP_LUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req = 1'b0;
    logic [8:0] Instr = 9'h000;
    logic [7:0] PC = 8'h00;
    logic       AluZero = 1'b0;
    logic       Start, StallCtr, Jen, Zero, Done;
    logic [7:0] Jump;
`ifdef JUMP_LUT_EN
    logic       LutWe = 1'b0;
    logic [3:0] LutAddr = 4'h0;
    logic [7:0] LutData = 8'h00;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    branch_ctrl dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Instr    (Instr),
        .PC       (PC),
        .AluZero  (AluZero),
`ifdef JUMP_LUT_EN
        .LutWe    (LutWe),
        .LutAddr  (LutAddr),
        .LutData  (LutData),
`endif
        .Start    (Start),
        .StallCtr (StallCtr),
        .Jen      (Jen),
        .Zero     (Zero),
        .Jump     (Jump),
        .Done     (Done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic st, input logic sc,
                              input logic jn, input logic zr, input logic dn);
        #1;
        check({tag, ".Start"},    {7'd0, Start},    {7'd0, st});
        check({tag, ".StallCtr"}, {7'd0, StallCtr}, {7'd0, sc});
        check({tag, ".Jen"},      {7'd0, Jen},      {7'd0, jn});
        check({tag, ".Zero"},     {7'd0, Zero},     {7'd0, zr});
        check({tag, ".Done"},     {7'd0, Done},     {7'd0, dn});
    endtask

    initial begin
        // Reset held two cycles with Req high.
        Reset = 1'b1; Req = 1'b1; PC = 8'h33;
        tick();
        check_ctrl("rst1", 1, 0, 0, 0, 0);
        check("rst1.Jump", Jump, 8'h00);
`ifdef JUMP_LUT_EN
        LutWe = 1'b1; LutAddr = 4'd5; LutData = 8'h42;
`endif
        tick();
        check_ctrl("rst2", 1, 0, 0, 0, 0);
        Reset = 1'b0; Instr = 9'h000;
`ifdef JUMP_LUT_EN
        LutWe = 1'b0;
`endif
        tick();
        check_ctrl("run_entry", 0, 0, 0, 0, 0);
        check("nop.Jump", Jump, 8'h00);

        // Compare loads Zero at the edge.
        Instr = 9'h140; AluZero = 1'b1;
        check_ctrl("cmp1_cycle", 0, 0, 0, 0, 0);
        tick();
        // Memory op: StallCtr high for exactly 4 cycles, Zero held.
        Instr = 9'h180; AluZero = 1'b0;
        check_ctrl("mem_c0", 0, 1, 0, 1, 0);
        tick();
        check_ctrl("mem_c1", 0, 1, 0, 1, 0);
        tick();
        check_ctrl("mem_c2", 0, 1, 0, 1, 0);
        tick();
        check_ctrl("mem_c3", 0, 1, 0, 1, 0);
        tick();
        Instr = 9'h000;
        check_ctrl("mem_after", 0, 0, 0, 1, 0);

        // Compare with AluZero=0 clears Zero.
        Instr = 9'h140; AluZero = 1'b0;
        tick();
        check_ctrl("cmp0", 0, 0, 0, 0, 0);
        // Compare AluZero=1 then branch: branch sees registered Zero only.
        AluZero = 1'b1;
        tick();
        Instr = 9'h1DF; PC = 8'hF0; AluZero = 1'b0;
        check_ctrl("brz_z1", 0, 0, 1, 1, 0);
`ifndef JUMP_LUT_EN
        check("brz_z1.Jump", Jump, 8'h0F);
`endif
        tick();
        check_ctrl("brz_nobypass", 0, 0, 1, 1, 0);
        Instr = 9'h140; AluZero = 1'b0;
        tick();
        Instr = 9'h1DF; PC = 8'hF0; AluZero = 1'b1;
        check_ctrl("brz_z0", 0, 0, 1, 0, 0);
`ifndef JUMP_LUT_EN
        check("brz_z0.Jump", Jump, 8'h0F);
        Instr = 9'h1E0; PC = 8'h10;
        #1;
        check("brz_neg.Jump", Jump, 8'hF0);
`else
        LutWe = 1'b1; LutAddr = 4'd5; LutData = 8'h99;
        tick();
        LutWe = 1'b0;
        Instr = 9'h1E5;
        #1;
        check("lut5.Jump", Jump, 8'h42);
`endif
        Instr = 9'h005; PC = 8'h77;
        #1;
        check("nojen.Jump", Jump, 8'h00);

        // Halt: wins over branch decode, then DONE until Req drops.
        Instr = 9'h1FF;
        check_ctrl("halt_cycle", 0, 0, 0, 0, 0);
        check("halt.Jump", Jump, 8'h00);
        tick();
        check_ctrl("done1", 1, 0, 0, 0, 1);
        tick();
        check_ctrl("done_hold", 1, 0, 0, 0, 1);
        Req = 1'b0;
        tick();
        check_ctrl("idle_back", 1, 0, 0, 0, 0);

        // Reset on the second STALL cycle.
        Req = 1'b1; Instr = 9'h000;
        tick();
        check_ctrl("run2", 0, 0, 0, 0, 0);
        Instr = 9'h180;
        tick();
        check_ctrl("stall1", 0, 1, 0, 0, 0);
        tick();
        check_ctrl("stall2", 0, 1, 0, 0, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0; Req = 1'b0;
        check_ctrl("rst_mid_stall", 1, 0, 0, 0, 0);
        tick();
        check_ctrl("idle_after_rst", 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $fatal(1, "FAIL timeout: observed=running expected=finished");
    end

endmodule

`default_nettype wire
